pwm_ramp_ctrl: RTL
==================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameters SHALL be: STEP, default 1, duty increment per step (1..100); PERIODS_PER_STEP, default 4, PWM periods per step (1..256).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 tgt_dc  in  7  requested duty cycle, percent.
REQ-005 tgt_valid  in  1  request present; held stable until accepted.
REQ-006 tgt_ready  out  1  controller can accept a request.
REQ-007 period_tick  in  1  one-cycle pulse at PWM counter wrap.
REQ-008 dc  out  7  duty cycle driven to the PWM generator, registered.
REQ-009 busy  out  1  ramp in progress.
REQ-010 done  out  1  ramp-complete pulse; present only with PWM_RAMP_DONE_EN.

Function
REQ-011 States SHALL be IDLE and RAMP.
REQ-012 tgt_ready SHALL equal 1 in IDLE and 0 in RAMP; busy SHALL be its inverse.
REQ-013 A request is accepted on an edge with tgt_valid=1 and tgt_ready=1.
REQ-014 At acceptance, a tgt_dc value above 100 SHALL be clamped to 100 and latched as the target.
REQ-015 If the clamped target equals dc, the block SHALL stay in IDLE with no busy and no done.
REQ-016 Otherwise the block SHALL enter RAMP on that edge with the tick counter cleared to 0.
REQ-017 In RAMP, each period_tick SHALL increment the tick counter.
REQ-018 On the tick where the counter equals PERIODS_PER_STEP-1, dc SHALL move toward the target by min(STEP, |target-dc|) and the counter SHALL clear.
REQ-019 dc SHALL change only on edges where period_tick=1, so duty updates align to PWM period boundaries.
REQ-020 On the edge where dc reaches the target, the state SHALL return to IDLE, so tgt_ready=1 the next cycle.
REQ-021 In IDLE, period_tick SHALL be ignored and the counter held at 0.
REQ-022 tgt_valid during RAMP SHALL be ignored, with no retarget and no abort.
REQ-023 Duty arithmetic SHALL use 8-bit unsigned; dc SHALL never exceed 100 nor wrap below 0.
REQ-024 The tick counter SHALL be 8 bits wide.

Reset
REQ-025 reset=1 SHALL immediately force: dc=0, state IDLE, target=0, counter=0, tgt_ready=1, busy=0, done=0.
REQ-026 Reset mid-ramp SHALL abandon the ramp with no completion pulse.
REQ-027 After reset deasserts, the first edge may accept a request.

Configuration
REQ-028 With PWM_RAMP_DONE_EN defined, the done port SHALL exist.
REQ-029 done SHALL pulse high for exactly one cycle, on the cycle after the edge where dc reached the target.
REQ-030 Without PWM_RAMP_DONE_EN, the done port and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package pwm_pkg SHALL hold: DC_W=7, DC_MAX=100, the state enum type (IDLE, RAMP) and the tick counter width constant.
REQ-032 The period prescaler SHALL be a sub-module, pwm_tick_div.
REQ-033 pwm_tick_div SHALL count period_tick pulses and emit a one-cycle step strobe.
REQ-034 pwm_tick_div SHALL be cleared at acceptance and in IDLE.

Verification (STEP=1, PERIODS_PER_STEP=4 unless stated)
REQ-035 Reset: assert reset mid-cycle -> dc=0, tgt_ready=1, busy=0 without waiting for a clock edge.
REQ-036 Up-ramp: accept tgt_dc=10 from dc=0 -> dc increments on every 4th period_tick and reaches 10 after 40 ticks; done pulses once; tgt_ready=1 on the next cycle.
REQ-037 Clamp: tgt_dc=120 from dc=0 -> dc stops at 100; tick 401 causes no change.
REQ-038 Down-ramp with STEP=3, PERIODS_PER_STEP=1: from dc=10, tgt_dc=5 -> dc sequence 10, 7, 5, then IDLE.
REQ-039 Request during RAMP: tgt_dc=50 held during a ramp to 10 -> not accepted until IDLE, then ramps 10 to 50.
REQ-040 Reset mid-ramp at dc=5 -> dc=0 immediately, no done pulse; a new tgt_dc=0 request stays IDLE with no busy.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, limits, state type and clamp helper for the PWM ramp controller
//   DC_W    duty-cycle width in bits
//   DC_MAX  highest legal duty cycle, percent
//   CNT_W   period-tick prescaler counter width
//   state_t controller states IDLE / RAMP
package pwm_pkg;
    localparam int DC_W = 7;
    localparam logic [DC_W-1:0] DC_MAX = 7'd100;
    localparam int CNT_W = 8;
    typedef enum logic {IDLE, RAMP} state_t;
    function automatic logic [DC_W-1:0] clamp_dc(input logic [DC_W-1:0] v);
        return v > DC_MAX ? DC_MAX : v;
    endfunction
endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: request / PWM-side bundle of the ramp controller
//   tgt_dc, tgt_valid, tgt_ready  target request handshake
//   period_tick                   one-cycle pulse at PWM counter wrap
//   dc, busy                      duty cycle to the PWM generator, ramp-in-progress flag
//   done                          ramp-complete pulse, only with PWM_RAMP_DONE_EN defined
interface pwm_ramp_ctrl_if;
    import pwm_pkg::*;
    logic [DC_W-1:0] tgt_dc;
    logic            tgt_valid;
    logic            tgt_ready;
    logic            period_tick;
    logic [DC_W-1:0] dc;
    logic            busy;
`ifdef PWM_RAMP_DONE_EN
    logic            done;
    modport master (output tgt_dc, tgt_valid, period_tick, input tgt_ready, dc, busy, done);
    modport slave  (input tgt_dc, tgt_valid, period_tick, output tgt_ready, dc, busy, done);
`else
    modport master (output tgt_dc, tgt_valid, period_tick, input tgt_ready, dc, busy);
    modport slave  (input tgt_dc, tgt_valid, period_tick, output tgt_ready, dc, busy);
`endif
endinterface

// File: rtl/pwm_tick_div.sv
// pwm_tick_div: counts PWM period ticks and strobes once every PERIODS_PER_STEP ticks
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_clr           hold the count at zero
//   i_tick          PWM period tick
//   o_step          one-cycle strobe on the tick that completes a step interval
module pwm_tick_div
    import pwm_pkg::*;
#(
    parameter int PERIODS_PER_STEP = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_tick,
    output logic o_step
);
    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;
    assign w_wrap = r_cnt == CNT_W'(PERIODS_PER_STEP - 1);
    assign o_step = i_tick && !i_clr && w_wrap;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_tick)
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps the PWM duty cycle toward a requested target in bounded steps on period boundaries
//   i_clk, i_reset  clock, asynchronous active-high reset
//   bus             pwm_ramp_ctrl_if slave: request handshake, period tick, dc/busy outputs
//   optional done pulse on the bus when PWM_RAMP_DONE_EN is defined
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int STEP             = 1,
    parameter int PERIODS_PER_STEP = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    pwm_ramp_ctrl_if.slave bus
);
    state_t          r_state, w_state_nxt;
    logic [DC_W-1:0] r_dc, r_tgt, w_dc_nxt, w_tgt_nxt, w_req;
    logic [7:0]      w_dc8, w_tgt8, w_dist, w_mv;
    logic            w_step;

    // the prescaler only runs while ramping, so every ramp starts from a zero count
    pwm_tick_div #(.PERIODS_PER_STEP(PERIODS_PER_STEP)) u_div (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clr  (r_state == IDLE),
        .i_tick (bus.period_tick),
        .o_step (w_step)
    );

    assign w_req  = clamp_dc(bus.tgt_dc);
    assign w_dc8  = {1'b0, r_dc};
    assign w_tgt8 = {1'b0, r_tgt};
    assign w_dist = w_tgt8 > w_dc8 ? w_tgt8 - w_dc8 : w_dc8 - w_tgt8;
    // the last step shrinks to the remaining distance, so dc lands exactly on target
    assign w_mv   = w_dist < 8'(STEP) ? w_dist : 8'(STEP);

    always_comb begin
        w_state_nxt = r_state;
        w_dc_nxt    = r_dc;
        w_tgt_nxt   = r_tgt;
        if (r_state == IDLE) begin
            if (bus.tgt_valid) begin
                w_tgt_nxt   = w_req;
                w_state_nxt = w_req == r_dc ? IDLE : RAMP;
            end
        end else if (w_step) begin
            w_dc_nxt    = DC_W'(w_tgt8 > w_dc8 ? w_dc8 + w_mv : w_dc8 - w_mv);
            w_state_nxt = w_dc_nxt == r_tgt ? IDLE : RAMP;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_dc    <= '0;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dc    <= w_dc_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    assign bus.dc        = r_dc;
    assign bus.tgt_ready = r_state == IDLE;
    assign bus.busy      = r_state == RAMP;

`ifdef PWM_RAMP_DONE_EN
    logic r_done;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_done <= 1'b0;
        else
            r_done <= r_state == RAMP && w_state_nxt == IDLE;
    end
    assign bus.done = r_done;
`endif
endmodule
